// File: rtl/silife_sync_pkg.sv
// Shared types and helpers for the edge serdes: FSM states, beat count, synchroniser depth.
package silife_sync_pkg;

   localparam int unsigned SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      XFER   = 2'd1,
      COMMIT = 2'd2
   } sync_state_e;

   // Beats needed to carry WIDTH cells plus the corner cell over `lanes` lines.
   function automatic int unsigned beats(input int unsigned width, input int unsigned lanes);
      return (width + lanes) / lanes;
   endfunction

endpackage

// File: rtl/silife_sync_2ff.sv
// Multi-stage flop synchroniser for signals arriving from the peer chip.
module silife_sync_2ff
   import silife_sync_pkg::*;
#(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [SYNC_STAGES-1:0][W-1:0] stg_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) stg_q <= '0;
      else          stg_q <= {stg_q[SYNC_STAGES-2:0], d};
   end

   assign q = stg_q[SYNC_STAGES-1];

endmodule

// File: rtl/silife_edge_serdes.sv
// One grid edge exchanged with the neighbouring chip over LANES serial lines per generation;
// sync clock is either generated here (master) or taken from the peer (slave).
module silife_edge_serdes
   import silife_sync_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned LANES   = 1,
   parameter int unsigned CLK_DIV = 8,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_enable,
   input  logic             i_master,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_cells,
   input  logic             i_corner,
   output logic [WIDTH-1:0] o_cells,
   output logic             o_corner,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_error,
   input  logic             i_sync_clk,
   output logic             o_sync_clk,
   input  logic [LANES-1:0] i_sync_in,
   output logic [LANES-1:0] o_sync_out
);

   localparam int unsigned BEATS = beats(WIDTH, LANES);
   localparam int unsigned FW    = BEATS * LANES;
   localparam int unsigned CNT_W = $clog2(BEATS + 1);
   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   sync_state_e      state_q, state_d;
   logic             mode_q, mode_d;
   logic [FW-1:0]    tx_q, tx_d, rx_q, rx_d, frame;
   logic [CNT_W-1:0] beat_q, beat_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             sclk_q, sclk_d;
   logic [LANES-1:0] sout_q, sout_d;
   logic [WIDTH-1:0] cells_q, cells_d;
   logic             corner_q, corner_d, busy_q, done_q, done_d, error_q, error_d;
   logic             sclk_s, sclk_prev_q, det_rise, det_fall;
   logic [LANES-1:0] sin_s;
   logic             toggle, rise_ev, fall_ev;

   silife_sync_2ff #(.W(1)) u_sync_clk (
      .clk(clk), .reset_n(reset_n), .d(i_sync_clk), .q(sclk_s));

   silife_sync_2ff #(.W(LANES)) u_sync_in (
      .clk(clk), .reset_n(reset_n), .d(i_sync_in), .q(sin_s));

   assign frame    = FW'({i_cells, i_corner});
   assign det_rise = sclk_s & ~sclk_prev_q;
   assign det_fall = ~sclk_s & sclk_prev_q;

   // Next-state and next-output logic; rise/fall events unify master and slave timing.
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      beat_d   = beat_q;
      div_d    = div_q;
      tmo_d    = tmo_q;
      sclk_d   = sclk_q;
      sout_d   = sout_q;
      cells_d  = cells_q;
      corner_d = corner_q;
      done_d   = 1'b0;
      error_d  = error_q;
      toggle   = 1'b0;
      rise_ev  = 1'b0;
      fall_ev  = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_start && i_enable) begin
               state_d = XFER;
               mode_d  = i_master;
               tx_d    = frame >> LANES;
               sout_d  = frame[LANES-1:0];
               rx_d    = '0;
               beat_d  = '0;
               div_d   = '0;
               tmo_d   = '0;
               sclk_d  = 1'b0;
               error_d = 1'b0;
            end
         end
         XFER: begin
            if (mode_q) begin
               toggle  = (div_q == DIV_W'(CLK_DIV - 1));
               div_d   = toggle ? '0 : div_q + DIV_W'(1);
               rise_ev = toggle & ~sclk_q;
               fall_ev = toggle & sclk_q;
               if (toggle) sclk_d = ~sclk_q;
            end else begin
               rise_ev = det_rise;
               fall_ev = det_fall;
               tmo_d   = (det_rise | det_fall) ? '0 : tmo_q + TMO_W'(1);
            end
            if (rise_ev && beat_q != CNT_W'(BEATS)) begin
               rx_d   = (rx_q >> LANES) | (FW'(sin_s) << (FW - LANES));
               beat_d = beat_q + CNT_W'(1);
            end
            if (fall_ev) begin
               if (beat_q == CNT_W'(BEATS)) begin
                  state_d  = COMMIT;
                  cells_d  = rx_q[WIDTH:1];
                  corner_d = rx_q[0];
                  done_d   = 1'b1;
               end else begin
                  sout_d = tx_q[LANES-1:0];
                  tx_d   = tx_q >> LANES;
               end
            end
            // Peer stopped clocking: abandon the frame, keep the last committed cells.
            if (!mode_q && !(det_rise | det_fall) && tmo_q == TMO_W'(TIMEOUT - 1)) begin
               state_d = IDLE;
               error_d = 1'b1;
               sout_d  = '0;
               sclk_d  = 1'b0;
            end
         end
         COMMIT: begin
            state_d = IDLE;
            sout_d  = '0;
         end
         default: state_d = IDLE;
      endcase

      if (state_q != IDLE && !i_enable) begin
         state_d = IDLE;
         done_d  = 1'b0;
         sclk_d  = 1'b0;
         sout_d  = '0;
         error_d = error_q;
      end
      if (!i_enable) begin
         cells_d  = '0;
         corner_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         mode_q      <= 1'b0;
         tx_q        <= '0;
         rx_q        <= '0;
         beat_q      <= '0;
         div_q       <= '0;
         tmo_q       <= '0;
         sclk_q      <= 1'b0;
         sout_q      <= '0;
         cells_q     <= '0;
         corner_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         sclk_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         beat_q      <= beat_d;
         div_q       <= div_d;
         tmo_q       <= tmo_d;
         sclk_q      <= sclk_d;
         sout_q      <= sout_d;
         cells_q     <= cells_d;
         corner_q    <= corner_d;
         busy_q      <= (state_d != IDLE);
         done_q      <= done_d;
         error_q     <= error_d;
         sclk_prev_q <= sclk_s;
      end
   end

   assign o_cells    = cells_q;
   assign o_corner   = corner_q;
   assign o_busy     = busy_q;
   assign o_done     = done_q;
   assign o_error    = error_q;
   assign o_sync_clk = sclk_q;
   assign o_sync_out = sout_q;

endmodule
